// File: rtl/instr_feeder_if.sv
// Producer-side valid/ready bus carrying 32-bit instruction words into instr_feeder.
interface instr_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready
    );
endinterface

// File: rtl/instr_feeder.sv
// FIFO-buffered instruction issuer for the single-cycle core; substitutes NOP bubbles when idle.
// Optional opcode filtering at enqueue is enabled by defining INSTR_FEEDER_OPCODE_FILTER_EN.
module instr_feeder #(
    parameter int          DEPTH = 16,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_feeder_if.slave            bus,
    input  logic                     run,
    input  logic                     flush,
    output logic [31:0]              Instr,
    output logic                     instr_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              issued_cnt,
    output logic [15:0]              bubble_cnt,
    output logic [15:0]              illegal_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [31:0]   store_word;

    // A full FIFO refuses pushes even when a pop frees a slot at the same edge.
    assign bus.in_ready = !rst && !flush && (count < FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = run && (count != '0);

`ifdef INSTR_FEEDER_OPCODE_FILTER_EN
    logic illegal_word;

    assign illegal_word = !(bus.in_instr[6:0] inside {7'd3, 7'd35, 7'd51, 7'd99, 7'd19, 7'd111});
    assign store_word   = illegal_word ? NOP : bus.in_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && illegal_word && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`else
    assign store_word  = bus.in_instr;
    assign illegal_cnt = '0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= store_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            Instr       <= NOP;
            instr_valid <= 1'b0;
            issued_cnt  <= '0;
            bubble_cnt  <= '0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            Instr       <= NOP;
            instr_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // Pop only sees words stored before this edge, so a fresh push never bypasses.
            if (pop) begin
                Instr       <= mem[rd_ptr];
                instr_valid <= 1'b1;
                rd_ptr      <= rd_ptr + 1'b1;
                issued_cnt  <= issued_cnt + 32'd1;
            end else begin
                Instr       <= NOP;
                instr_valid <= 1'b0;
                if (run && (bubble_cnt != 16'hFFFF)) begin
                    bubble_cnt <= bubble_cnt + 16'd1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
